ulpi_recv_pck: RTL and testbench

- ULPI receive-direction engine: consumes PHY-driven bus cycles while DIR is high.
- Classifies each cycle as turnaround, RX CMD or USB data byte, and frames received packets (SOP/EOP/error/length).
- Sits beside the register read/write engines inside the ULPI link controller.
- The controller enables it in its receive-packet state and returns to IDLE when BUSY falls.

---
 rtl/ulpi_defs.sv | 32 +++
 rtl/ulpi_recv_pck.sv | 157 +++++++++++++++
 tb/tb_ulpi_recv_pck.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_defs.sv
// Shared definitions for the ULPI receive-direction engine: state encodings,
// RX CMD field layout and RX_EVENT codes.
package ulpi_defs;

  localparam int unsigned MAX_LEN_DEF = 1027;
  localparam int unsigned LEN_W_DEF   = 11;

  // RX CMD byte layout: LineState in [1:0], RxEvent in [5:4]
  localparam int unsigned LS_LSB  = 0;
  localparam int unsigned EV_LSB  = 4;
  localparam int unsigned FIELD_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TURN_IN  = 3'd1,
    ST_OWNED    = 3'd2,
    ST_PKT      = 3'd3,
    ST_TURN_OUT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE      = 2'b00,
    EV_ACTIVE    = 2'b01,
    EV_HOST_DISC = 2'b10,
    EV_ERROR     = 2'b11
  } rx_event_t;

  function automatic rx_event_t rx_event_of(input logic [7:0] cmd);
    return rx_event_t'(cmd[EV_LSB +: FIELD_W]);
  endfunction

endpackage

// File: rtl/ulpi_recv_pck.sv
// ULPI receive-direction engine: classifies PHY-driven bus cycles into
// turnaround, RX CMD and USB data bytes, and frames received packets.
module ulpi_recv_pck
  import ulpi_defs::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input  logic             clk_ext,
  input  logic             rst,
  input  logic             EN,
  input  logic             DIR,
  input  logic             NXT,
  input  logic [7:0]       ULPI_DATA_IN,
  output logic [7:0]       RX_CMD,
  output logic             RX_CMD_VLD,
  output logic [1:0]       LINE_STATE,
  output logic [1:0]       RX_EVENT,
  output logic [7:0]       PCK_DATA,
  output logic             PCK_VLD,
  output logic             PCK_SOP,
  output logic             PCK_EOP,
  output logic             PCK_ERR,
  output logic [LEN_W-1:0] PCK_LEN,
  output logic             BUSY
);

  state_t            state, state_nxt;
  logic              in_pkt, in_pkt_nxt;
  logic              err, err_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt, cnt_inc;
  rx_event_t         ev;

  logic [7:0]        rx_cmd_d;
  logic              rx_cmd_vld_d;
  logic [7:0]        pck_data_d;
  logic              pck_vld_d, pck_sop_d, pck_eop_d, pck_err_d;
  logic [LEN_W-1:0]  pck_len_d;
  logic              capture, eop_req;

  assign ev      = rx_event_of(ULPI_DATA_IN);
  assign cnt_inc = (cnt == {LEN_W{1'b1}}) ? cnt : cnt + LEN_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    in_pkt_nxt   = in_pkt;
    err_nxt      = err;
    cnt_nxt      = cnt;
    rx_cmd_d     = RX_CMD;
    rx_cmd_vld_d = 1'b0;
    pck_data_d   = PCK_DATA;
    pck_vld_d    = 1'b0;
    pck_sop_d    = 1'b0;
    pck_eop_d    = 1'b0;
    pck_err_d    = 1'b0;
    pck_len_d    = PCK_LEN;
    capture      = 1'b0;
    eop_req      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (EN && DIR) begin
          state_nxt  = ST_TURN_IN;
          in_pkt_nxt = NXT;
        end
      end
      ST_TURN_IN: begin
        in_pkt_nxt = 1'b0;
        if (!DIR)        state_nxt = ST_TURN_OUT;
        else if (in_pkt) state_nxt = ST_PKT;
        else             state_nxt = ST_OWNED;
      end
      ST_OWNED: begin
        if (!DIR) begin
          state_nxt = ST_TURN_OUT;
        end else if (!NXT) begin
          capture = 1'b1;
          if (ev == EV_ACTIVE) state_nxt = ST_PKT;
        end
      end
      ST_PKT: begin
        if (!DIR) begin
          eop_req   = 1'b1;
          state_nxt = ST_TURN_OUT;
        end else if (NXT) begin
          pck_vld_d  = 1'b1;
          pck_data_d = ULPI_DATA_IN;
          pck_sop_d  = (cnt == '0);
          cnt_nxt    = cnt_inc;
          if (32'(cnt_inc) > MAX_LEN) err_nxt = 1'b1;
        end else begin
          capture = 1'b1;
          if (ev == EV_ERROR) err_nxt = 1'b1;
          if (ev == EV_NONE || ev == EV_HOST_DISC) begin
            eop_req   = 1'b1;
            state_nxt = ST_OWNED;
          end
        end
      end
      ST_TURN_OUT: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase

    if (capture) begin
      rx_cmd_d     = ULPI_DATA_IN;
      rx_cmd_vld_d = 1'b1;
    end

    // A packet that delivered no bytes is always reported as bad
    if (eop_req) begin
      pck_eop_d = 1'b1;
      pck_err_d = err_nxt || (cnt == '0);
      pck_len_d = cnt;
      err_nxt   = 1'b0;
      cnt_nxt   = '0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_ext or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      in_pkt     <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      RX_CMD     <= '0;
      RX_CMD_VLD <= 1'b0;
      LINE_STATE <= '0;
      RX_EVENT   <= '0;
      PCK_DATA   <= '0;
      PCK_VLD    <= 1'b0;
      PCK_SOP    <= 1'b0;
      PCK_EOP    <= 1'b0;
      PCK_ERR    <= 1'b0;
      PCK_LEN    <= '0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_pkt     <= in_pkt_nxt;
      err        <= err_nxt;
      cnt        <= cnt_nxt;
      RX_CMD     <= rx_cmd_d;
      RX_CMD_VLD <= rx_cmd_vld_d;
      LINE_STATE <= rx_cmd_d[LS_LSB +: FIELD_W];
      RX_EVENT   <= rx_cmd_d[EV_LSB +: FIELD_W];
      PCK_DATA   <= pck_data_d;
      PCK_VLD    <= pck_vld_d;
      PCK_SOP    <= pck_sop_d;
      PCK_EOP    <= pck_eop_d;
      PCK_ERR    <= pck_err_d;
      PCK_LEN    <= pck_len_d;
      BUSY       <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ulpi_recv_pck.sv
// Randomized and directed bench for ulpi_recv_pck, checked every cycle against
// a bus-session/packet-queue reference model.
module tb_ulpi_recv_pck;

  localparam int unsigned MAX_LEN = 1027;
  localparam int unsigned LEN_W   = 11;
  localparam int unsigned LEN_SAT = (1 << LEN_W) - 1;

  logic             clk_ext = 1'b0;
  logic             rst;
  logic             EN, DIR, NXT;
  logic [7:0]       ULPI_DATA_IN;
  logic [7:0]       RX_CMD;
  logic             RX_CMD_VLD;
  logic [1:0]       LINE_STATE, RX_EVENT;
  logic [7:0]       PCK_DATA;
  logic             PCK_VLD, PCK_SOP, PCK_EOP, PCK_ERR;
  logic [LEN_W-1:0] PCK_LEN;
  logic             BUSY;

  ulpi_recv_pck #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk_ext(clk_ext), .rst(rst), .EN(EN), .DIR(DIR), .NXT(NXT),
    .ULPI_DATA_IN(ULPI_DATA_IN), .RX_CMD(RX_CMD), .RX_CMD_VLD(RX_CMD_VLD),
    .LINE_STATE(LINE_STATE), .RX_EVENT(RX_EVENT), .PCK_DATA(PCK_DATA),
    .PCK_VLD(PCK_VLD), .PCK_SOP(PCK_SOP), .PCK_EOP(PCK_EOP), .PCK_ERR(PCK_ERR),
    .PCK_LEN(PCK_LEN), .BUSY(BUSY)
  );

  always #5 clk_ext = ~clk_ext;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a session opens on DIR while idle, its first owned cycle
  // is a turnaround, and bytes of an open packet collect in a queue.
  bit         m_busy, m_tout, m_turn, m_pkt, m_errseen;
  logic [7:0] pkt_q[$];
  logic [7:0] m_rx_cmd;
  logic [7:0] e_data;
  int         e_len;
  bit         e_rx_vld, e_vld, e_sop, e_eop, e_err;

  task automatic model_reset();
    m_busy = 0; m_tout = 0; m_turn = 0; m_pkt = 0; m_errseen = 0;
    pkt_q.delete();
    m_rx_cmd = '0; e_data = '0; e_len = 0;
    e_rx_vld = 0; e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0;
  endtask

  task automatic close_pkt();
    int n;
    n      = pkt_q.size();
    e_eop  = 1;
    e_len  = (n > int'(LEN_SAT)) ? int'(LEN_SAT) : n;
    e_err  = m_errseen || (n == 0) || (n > int'(MAX_LEN));
    pkt_q.delete();
    m_errseen = 0;
    m_pkt     = 0;
  endtask

  task automatic model_step(input bit en, input bit dir, input bit nxt, input logic [7:0] d);
    logic [1:0] evc;
    e_rx_vld = 0; e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0;
    evc = d[5:4];
    if (m_tout) begin
      m_tout = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (en && dir) begin
        m_busy = 1; m_turn = 1; m_pkt = nxt;
      end
    end else if (!dir) begin
      if (m_pkt && !m_turn) close_pkt();
      m_pkt = 0; m_turn = 0; m_tout = 1;
    end else if (m_turn) begin
      m_turn = 0;
    end else if (nxt) begin
      if (m_pkt) begin
        e_vld  = 1;
        e_sop  = (pkt_q.size() == 0);
        e_data = d;
        pkt_q.push_back(d);
      end
    end else begin
      e_rx_vld = 1;
      m_rx_cmd = d;
      if (m_pkt) begin
        if (evc == 2'b11) m_errseen = 1;
        if (evc == 2'b00 || evc == 2'b10) close_pkt();
      end else if (evc == 2'b01) begin
        m_pkt = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("busy",       32'(BUSY),       32'(m_busy));
    chk("rx_cmd",     32'(RX_CMD),     32'(m_rx_cmd));
    chk("line_state", 32'(LINE_STATE), 32'(m_rx_cmd[1:0]));
    chk("rx_event",   32'(RX_EVENT),   32'(m_rx_cmd[5:4]));
    chk("rx_cmd_vld", 32'(RX_CMD_VLD), 32'(e_rx_vld));
    chk("pck_vld",    32'(PCK_VLD),    32'(e_vld));
    chk("pck_sop",    32'(PCK_SOP),    32'(e_sop));
    chk("pck_eop",    32'(PCK_EOP),    32'(e_eop));
    chk("pck_err",    32'(PCK_ERR),    32'(e_err));
    if (e_vld) chk("pck_data", 32'(PCK_DATA), 32'(e_data));
    if (e_eop) chk("pck_len",  32'(PCK_LEN),  32'(e_len));
  endtask

  task automatic drive(input bit en, input bit dir, input bit nxt, input logic [7:0] d);
    EN = en; DIR = dir; NXT = nxt; ULPI_DATA_IN = d;
    @(posedge clk_ext);
    model_step(en, dir, nxt, d);
    #1 compare_all();
  endtask

  task automatic start_pkt();
    drive(1, 1, 1, 8'($urandom));
    drive(1, 1, 1, 8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive(1, 1, 1, d);
  endtask

  task automatic send_cmd(input logic [7:0] d);
    drive(1, 1, 0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pk[4];
    pk[0] = 8'hC3; pk[1] = 8'h01; pk[2] = 8'h02; pk[3] = 8'h03;

    rst = 1'b0; EN = 0; DIR = 0; NXT = 0; ULPI_DATA_IN = '0;
    model_reset();
    repeat (2) begin
      @(posedge clk_ext);
      #1 compare_all();
      chk("rst_len",  32'(PCK_LEN),  32'd0);
      chk("rst_data", 32'(PCK_DATA), 32'd0);
    end
    @(negedge clk_ext) rst = 1'b1;

    // EN low holds the engine idle even with DIR high
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 8'($urandom));
    chk("en_low_busy", 32'(BUSY), 32'd0);
    drive(1, 1, 0, 8'h00);
    chk("en_rise_busy", 32'(BUSY), 32'd1);
    drive(1, 1, 0, 8'hAA);
    send_cmd(8'h15);
    chk("cmd15_ls", 32'(LINE_STATE), 32'd1);
    chk("cmd15_ev", 32'(RX_EVENT),   32'd1);
    send_cmd(8'h02);
    chk("empty_err", 32'(PCK_ERR), 32'd1);
    chk("empty_len", 32'(PCK_LEN), 32'd0);
    idle(3);

    // Nominal 4-byte packet ended by an RX CMD, then DIR falls
    start_pkt();
    for (int i = 0; i < 4; i++) send_byte(pk[i]);
    send_cmd(8'h01);
    chk("pkt4_len", 32'(PCK_LEN), 32'd4);
    chk("pkt4_err", 32'(PCK_ERR), 32'd0);
    idle(1);
    chk("busy_tout", 32'(BUSY), 32'd1);
    idle(1);
    chk("busy_fall", 32'(BUSY), 32'd0);

    // RxError mid-packet
    start_pkt();
    send_byte(8'h11); send_byte(8'h22);
    send_cmd(8'h31);
    send_cmd(8'h00);
    chk("rxerr_err", 32'(PCK_ERR), 32'd1);
    chk("rxerr_len", 32'(PCK_LEN), 32'd2);
    idle(3);

    // Oversize packet ended by DIR falling
    start_pkt();
    for (int i = 0; i < 1028; i++) send_byte(8'($urandom));
    idle(1);
    chk("big_len", 32'(PCK_LEN), 32'd1028);
    chk("big_err", 32'(PCK_ERR), 32'd1);
    idle(2);

    // Counter saturation
    start_pkt();
    for (int i = 0; i < 2050; i++) send_byte(8'($urandom));
    idle(1);
    chk("sat_len", 32'(PCK_LEN), 32'(LEN_SAT));
    idle(2);

    // Asynchronous reset in the middle of a packet
    start_pkt();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    #2 rst = 1'b0;
    model_reset();
    #1 compare_all();
    chk("arst_len",  32'(PCK_LEN),  32'd0);
    chk("arst_data", 32'(PCK_DATA), 32'd0);
    @(posedge clk_ext);
    #1 compare_all();
    @(negedge clk_ext) rst = 1'b1;
    start_pkt();
    send_byte(8'h5A);
    chk("post_rst_sop", 32'(PCK_SOP), 32'd1);
    idle(3);

    // Random sessions with random NXT, bus content and EN
    for (int s = 0; s < 400; s++) begin
      int gap, len;
      gap = $urandom_range(1, 4);
      for (int i = 0; i < gap; i++) drive(1'($urandom % 8 != 0), 0, 1'($urandom), 8'($urandom));
      drive(1, 1, 1'($urandom), 8'($urandom));
      len = $urandom_range(2, 40);
      for (int i = 0; i < len; i++) drive(1'($urandom), 1, 1'($urandom % 3 != 0), 8'($urandom));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
